// File: rtl/mem_pipe_reg.sv
// Execute-to-memory pipeline register with the architectural condition codes,
// mispredict flag and sticky halt. Define INSTR_COUNT_EN to add instr_count.
module mem_pipe_reg #(
   parameter int W     = 64,
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   e_stat,
   input  logic [3:0]   e_icode,
   input  logic         e_cnd,
   input  logic [W-1:0] e_valE,
   input  logic [W-1:0] e_valA,
   input  logic [3:0]   e_dstE,
   input  logic [3:0]   e_dstM,
   input  logic         e_zf,
   input  logic         e_sf,
   input  logic         e_of,
   input  logic         M_stall,
   input  logic         M_bubble,
   input  logic         W_exc,
   output logic [2:0]   M_stat,
   output logic [3:0]   M_icode,
   output logic         M_cnd,
   output logic [W-1:0] M_valE,
   output logic [W-1:0] M_valA,
   output logic [3:0]   M_dstE,
   output logic [3:0]   M_dstM,
   output logic         cc_zf,
   output logic         cc_sf,
   output logic         cc_of,
   output logic         mispredict,
`ifdef INSTR_COUNT_EN
   output logic [CNT_W-1:0] instr_count,
`endif
   output logic         halted
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;

   logic load_p0;
   logic set_cc_p0;
   logic m_exc;

   assign load_p0   = ~M_bubble & ~M_stall;
   assign m_exc     = (M_stat != STAT_AOK);
   assign set_cc_p0 = (e_icode == I_OPQ) & (e_stat == STAT_AOK) & ~m_exc & ~W_exc & ~halted;

   // M register: reset and bubble both inject a NOP with no destinations
   always_ff @(posedge clk) begin
      if (rst || M_bubble) begin
         M_stat  <= STAT_AOK;
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (!M_stall) begin
         M_stat  <= e_stat;
         M_icode <= e_icode;
         M_cnd   <= e_cnd;
         M_valE  <= e_valE;
         M_valA  <= e_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= e_dstM;
      end
   end

   // CC tracks the op in execute, independent of M stall/bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (set_cc_p0) begin
         cc_zf <= e_zf;
         cc_sf <= e_sf;
         cc_of <= e_of;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         halted <= 1'b0;
      else if (load_p0 && (e_stat != STAT_AOK))
         halted <= 1'b1;
   end

   assign mispredict = (M_icode == I_JXX) & ~M_cnd;

`ifdef INSTR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         instr_count <= '0;
      else if (load_p0 && !halted && (e_icode != I_NOP) && (e_stat == STAT_AOK))
         instr_count <= instr_count + 1'b1;
   end
`endif

endmodule
